trivium_host_link: RTL and testbench

//  Host-side counterpart of the Trivium stream-cipher core. Loads an 80-bit key parallel, shifts it bit-serially

---
 rtl/trivium_host_link.sv | 177 +++++++++++++++++
 tb/tb_trivium_host_link.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_host_link.sv
// Host-side link for a Trivium core: serial key loader, plaintext byte feeder, ciphertext FIFO with fill code.
// Define TRIV_HOST_STATS_EN to add byte_cnt, a saturating count of ciphertext bytes pushed to the FIFO.
module trivium_host_link #(
    parameter int FIFO_DEPTH   = 16,
    parameter int LOW_WM       = 4,
    parameter int HIGH_WM      = 12,
    parameter int RESP_TIMEOUT = 8,
    parameter int INIT_TIMEOUT = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] key_in,
    input  logic        key_load,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        core_key,
    output logic        core_strob_key,
    output logic [7:0]  core_data,
    output logic        core_strob_data,
    output logic [1:0]  core_fifo_cnd,
    input  logic [7:0]  core_stream,
    input  logic        core_wt_sgn,
    input  logic [7:0]  core_sign_reg,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
`ifdef TRIV_HOST_STATS_EN
    output logic [31:0] byte_cnt,
`endif
    output logic [1:0]  fault
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TMAX = (INIT_TIMEOUT > RESP_TIMEOUT) ? INIT_TIMEOUT : RESP_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_KEY_SHIFT = 3'd1;
    localparam logic [2:0] S_KEY_WAIT  = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_WAIT_RESP = 3'd4;
    localparam logic [2:0] S_PAUSE     = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    logic [2:0]    state;
    logic [79:0]   key_sh;
    logic [6:0]    kcnt;
    logic [TW-1:0] tmr;
    logic [AW:0]   occ, occ_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [1:0]    cnd_next;
    logic          restart, core_err, running, push, pop, push_ok, overflow, accept;

    assign restart   = key_load && (state == S_IDLE || state == S_FAULT);
    assign core_err  = (core_sign_reg == 8'h04 || core_sign_reg == 8'h10) && state != S_IDLE && state != S_FAULT;
    // Ciphertext is captured whenever the core flags it while the link is running.
    assign running   = state == S_RUN || state == S_WAIT_RESP || state == S_PAUSE;
    assign push      = running && core_wt_sgn;
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && (occ != (AW+1)'(FIFO_DEPTH) || pop);
    assign overflow  = push && !push_ok;
    assign src_ready = state == S_RUN && occ < (AW+1)'(FIFO_DEPTH - 1) && core_sign_reg == 8'h01;
    assign accept    = src_valid && src_ready;
    assign busy      = state != S_IDLE && state != S_FAULT;
    assign out_valid = occ != '0;
    assign occ_next  = occ + (AW+1)'(push_ok) - (AW+1)'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            key_sh          <= '0;
            kcnt            <= '0;
            tmr             <= '0;
            core_key        <= 1'b0;
            core_strob_key  <= 1'b0;
            core_data       <= '0;
            core_strob_data <= 1'b0;
            fault           <= 2'b00;
        end else begin
            core_strob_data <= 1'b0;
            if (restart) begin
                state          <= S_KEY_SHIFT;
                fault          <= 2'b00;
                key_sh         <= {key_in[78:0], 1'b0};
                core_key       <= key_in[79];
                core_strob_key <= 1'b1;
                kcnt           <= '0;
            end else if (core_err || overflow) begin
                state          <= S_FAULT;
                fault          <= core_err ? 2'b10 : 2'b11;
                core_key       <= 1'b0;
                core_strob_key <= 1'b0;
            end else begin
                case (state)
                    S_KEY_SHIFT: begin
                        if (kcnt == 7'd79) begin
                            core_strob_key <= 1'b0;
                            core_key       <= 1'b0;
                            tmr            <= '0;
                            state          <= S_KEY_WAIT;
                        end else begin
                            core_key <= key_sh[79];
                            key_sh   <= {key_sh[78:0], 1'b0};
                            kcnt     <= kcnt + 7'd1;
                        end
                    end
                    S_KEY_WAIT: begin
                        if (core_sign_reg == 8'h01) state <= S_RUN;
                        else if (core_sign_reg == 8'h08) begin
                            state <= S_FAULT;
                            fault <= 2'b01;
                        end else if (tmr == TW'(INIT_TIMEOUT - 1)) begin
                            state <= S_FAULT;
                            fault <= 2'b10;
                        end else tmr <= tmr + 1'b1;
                    end
                    S_RUN: begin
                        if (accept) begin
                            core_data       <= src_data;
                            core_strob_data <= 1'b1;
                            tmr             <= '0;
                            state           <= S_WAIT_RESP;
                        end else if (core_sign_reg == 8'h02) state <= S_PAUSE;
                    end
                    S_WAIT_RESP: begin
                        if (core_wt_sgn) state <= S_RUN;
                        else if (tmr == TW'(RESP_TIMEOUT - 1)) begin
                            state <= S_FAULT;
                            fault <= 2'b10;
                        end else tmr <= tmr + 1'b1;
                    end
                    S_PAUSE: if (core_sign_reg == 8'h01) state <= S_RUN;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= core_stream;
    end

    always_comb begin
        cnd_next = 2'b01;
        if (occ_next == (AW+1)'(FIFO_DEPTH)) cnd_next = 2'b11;
        else if (occ_next >= (AW+1)'(HIGH_WM)) cnd_next = 2'b10;
        else if (occ_next <= (AW+1)'(LOW_WM)) cnd_next = 2'b00;
    end

    // out_data always holds the head entry; a push into an (effectively) empty FIFO bypasses the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            out_data      <= '0;
            core_fifo_cnd <= 2'b00;
        end else begin
            occ           <= occ_next;
            core_fifo_cnd <= cnd_next;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && occ == (AW+1)'(pop)) out_data <= core_stream;
            else if (pop && occ > (AW+1)'(1)) out_data <= mem[rd_ptr + 1'b1];
        end
    end

`ifdef TRIV_HOST_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) byte_cnt <= '0;
        else if (restart) byte_cnt <= '0;
        else if (push_ok && byte_cnt != 32'hFFFF_FFFF) byte_cnt <= byte_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_trivium_host_link.sv
// Bench for trivium_host_link: directed sequence with randomized bytes/keys, FIFO modelled as a byte queue.
module tb_trivium_host_link;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] key_in = '0;
    logic        key_load = 1'b0;
    logic [7:0]  src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic        core_key, core_strob_key, core_strob_data;
    logic [7:0]  core_data;
    logic [1:0]  core_fifo_cnd;
    logic [7:0]  core_stream = '0;
    logic        core_wt_sgn = 1'b0;
    logic [7:0]  core_sign_reg = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [1:0]  fault;

    int        checks = 0;
    int        errors = 0;
    logic [7:0] q[$];
    bit        rand_pop = 1'b0;

    trivium_host_link dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .core_key(core_key), .core_strob_key(core_strob_key), .core_data(core_data),
        .core_strob_data(core_strob_data), .core_fifo_cnd(core_fifo_cnd),
        .core_stream(core_stream), .core_wt_sgn(core_wt_sgn), .core_sign_reg(core_sign_reg),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string tag, bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endfunction

    function automatic logic [1:0] cnd_of(int n);
        if (n == 16) return 2'b11;
        if (n >= 12) return 2'b10;
        if (n <= 4) return 2'b00;
        return 2'b01;
    endfunction

    function automatic logic [79:0] rand_key();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    task automatic tick();
        bit p, u;
        logic [7:0] s;
        if (rand_pop) out_ready = 1'($urandom_range(0, 1));
        p = out_ready && q.size() != 0;
        u = core_wt_sgn;
        s = core_stream;
        @(posedge clk);
        #1;
        if (rst) q.delete();
        else begin
            if (p) void'(q.pop_front());
            if (u && q.size() < 16) q.push_back(s);
        end
        chk("out_valid", out_valid === (q.size() != 0));
        if (q.size() != 0) chk("out_data", out_data === q[0]);
        chk("fifo_cnd", core_fifo_cnd === cnd_of(q.size()));
    endtask

    task automatic key_shift(logic [79:0] k, int stop_at);
        key_in = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("fault_clr", fault === 2'b00);
        chk("busy_load", busy === 1'b1);
        for (int i = 0; i < 80; i++) begin
            if (i == stop_at) return;
            chk("strob_key", core_strob_key === 1'b1);
            chk("key_bit", core_key === k[79-i]);
            if (i == 30) begin
                key_in = ~k;
                key_load = 1'b1;
            end
            tick();
            key_load = 1'b0;
        end
        chk("strob_key_end", core_strob_key === 1'b0);
        chk("key_end", core_key === 1'b0);
    endtask

    task automatic send_byte(logic [7:0] d, logic [7:0] s, int dly);
        chk("src_ready", src_ready === (q.size() < 15));
        if (!src_ready) begin
            tick();
            return;
        end
        src_data = d;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        chk("strob_data", core_strob_data === 1'b1);
        chk("core_data", core_data === d);
        chk("ready_in_flight", src_ready === 1'b0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("strob_pulse", core_strob_data === 1'b0);
        end
        core_stream = s;
        core_wt_sgn = 1'b1;
        tick();
        core_wt_sgn = 1'b0;
        chk("fault_none", fault === 2'b00);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_key", core_key === 1'b0);
        chk("rst_strob_key", core_strob_key === 1'b0);
        chk("rst_core_data", core_data === 8'h00);
        chk("rst_strob_data", core_strob_data === 1'b0);
        chk("rst_cnd", core_fifo_cnd === 2'b00);
        chk("rst_out_data", out_data === 8'h00);
        chk("rst_out_valid", out_valid === 1'b0);
        chk("rst_busy", busy === 1'b0);
        chk("rst_fault", fault === 2'b00);
        chk("rst_src_ready", src_ready === 1'b0);
        rst = 1'b0;
        tick();

        key_shift(80'h0123_4567_89AB_CDEF_F00D, -1);
        repeat (3) begin
            tick();
            chk("kw_busy", busy === 1'b1);
            chk("kw_ready", src_ready === 1'b0);
        end
        core_sign_reg = 8'h01;
        tick();
        chk("run_ready", src_ready === 1'b1);

        send_byte(8'h5A, 8'hC3, 1);
        chk("first_out_data", out_data === 8'hC3);
        chk("first_out_valid", out_valid === 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        rand_pop = 1'b1;
        repeat (40) send_byte(8'($urandom), 8'($urandom), $urandom_range(1, 6));
        rand_pop = 1'b0;

        out_ready = 1'b1;
        repeat (16) tick();
        out_ready = 1'b0;
        core_sign_reg = 8'h02;
        src_data = 8'hA5;
        src_valid = 1'b1;
        #1;
        chk("pause_ready_now", src_ready === 1'b0);
        repeat (5) begin
            tick();
            chk("pause_ready", src_ready === 1'b0);
            chk("pause_strob", core_strob_data === 1'b0);
            chk("pause_busy", busy === 1'b1);
        end
        src_valid = 1'b0;
        core_sign_reg = 8'h01;
        tick();
        chk("resume_ready", src_ready === 1'b1);
        send_byte(8'($urandom), 8'($urandom), 2);

        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_byte(8'($urandom), 8'($urandom), 1);
        chk("occ15_ready", src_ready === 1'b0);
        chk("occ15_cnd", core_fifo_cnd === 2'b10);
        core_stream = 8'($urandom);
        core_wt_sgn = 1'b1;
        tick();
        core_wt_sgn = 1'b0;
        chk("full_cnd", core_fifo_cnd === 2'b11);
        chk("full_fault", fault === 2'b00);
        core_stream = 8'hEE;
        core_wt_sgn = 1'b1;
        tick();
        core_wt_sgn = 1'b0;
        chk("ovf_fault", fault === 2'b11);
        chk("ovf_busy", busy === 1'b0);
        out_ready = 1'b1;
        repeat (17) tick();
        out_ready = 1'b0;
        chk("drained", out_valid === 1'b0);

        core_sign_reg = 8'h00;
        key_shift(rand_key(), -1);
        core_sign_reg = 8'h01;
        tick();
        send_byte(8'($urandom), 8'($urandom), 3);
        src_data = 8'h3C;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        chk("to_strob", core_strob_data === 1'b1);
        repeat (7) begin
            tick();
            chk("to_wait_fault", fault === 2'b00);
        end
        chk("to_wait_busy", busy === 1'b1);
        tick();
        chk("to_fault", fault === 2'b10);
        chk("to_busy", busy === 1'b0);
        chk("to_strob_off", core_strob_data === 1'b0);

        core_sign_reg = 8'h00;
        key_shift(rand_key(), 40);
        rst = 1'b1;
        #1;
        chk("rst_async_strob", core_strob_key === 1'b0);
        tick();
        chk("rst_mid_busy", busy === 1'b0);
        chk("rst_mid_fault", fault === 2'b00);
        chk("rst_mid_strob", core_strob_key === 1'b0);
        chk("rst_mid_key", core_key === 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy === 1'b0);

        key_shift(rand_key(), -1);
        core_sign_reg = 8'h08;
        tick();
        chk("keyerr_fault", fault === 2'b01);
        chk("keyerr_busy", busy === 1'b0);

        core_sign_reg = 8'h00;
        key_shift(rand_key(), -1);
        core_sign_reg = 8'h01;
        tick();
        chk("err_run_ready", src_ready === 1'b1);
        core_sign_reg = 8'h10;
        tick();
        chk("coreerr_fault", fault === 2'b10);
        chk("coreerr_busy", busy === 1'b0);

        core_sign_reg = 8'h00;
        key_shift(rand_key(), -1);
        repeat (2046) tick();
        chk("init_wait_fault", fault === 2'b00);
        chk("init_wait_busy", busy === 1'b1);
        tick();
        chk("init_to_fault", fault === 2'b10);
        chk("init_to_busy", busy === 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
